instr_decode: RTL and testbench

Instruction decode stage between the 8×256 program ROM and the register file / ALU of the 4-bit datapath. It captures one or two ROM bytes per instruction and decodes them into register addresses, ALU operation select, immediate and write-back select. It signals completion to the controller FSM with a one-cycle `ack`, and latches a halt condition.

---
 rtl/instr_decode.sv | 113 +++++++++++
 tb/tb_instr_decode.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - byte-serial instruction decoder for the 4-bit datapath (optional DECODE_ILLEGAL_TRAP_EN)
module instr_decode (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] data_bus,
    output logic       ack,
    output logic       more,
    output logic [3:0] op_sel,
    output logic [2:0] rd_addr1,
    output logic [2:0] rd_addr2,
    output logic [2:0] wr_addr,
    output logic [3:0] imm,
    output logic       sel_wr_ula,
    output logic       wr_en,
    output logic       halted,
    output logic       trap,
    output logic [7:0] instr_cnt
);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_WAIT2 = 1'b1;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic       state;
    logic [3:0] op_q;
    logic [2:0] f_q;
    logic [3:0] opcode;
    logic       two_byte;
    logic       illegal;

    assign opcode   = data_bus[7:4];
    assign two_byte = (opcode != OP_NOP) && (opcode <= OP_LDI);
    assign illegal  = (opcode > OP_LDI) && (opcode != OP_HALT);
    assign more     = (state == S_WAIT2);

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic trap_q;
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= 4'h0;
            f_q        <= 3'h0;
            ack        <= 1'b0;
            op_sel     <= 4'h0;
            rd_addr1   <= 3'h0;
            rd_addr2   <= 3'h0;
            wr_addr    <= 3'h0;
            imm        <= 4'h0;
            sel_wr_ula <= 1'b0;
            wr_en      <= 1'b0;
            halted     <= 1'b0;
            instr_cnt  <= 8'h0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            ack <= 1'b0;
            if (ena && !halted) begin
                if (state == S_IDLE) begin
                    if (two_byte) begin
                        // Only the opcode and F[2:0] are needed once byte 1 arrives.
                        op_q  <= opcode;
                        f_q   <= data_bus[2:0];
                        state <= S_WAIT2;
                    end else begin
                        ack       <= 1'b1;
                        instr_cnt <= instr_cnt + 8'd1;
                        wr_en     <= 1'b0;
                        if (opcode == OP_HALT)
                            halted <= 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
                        if (illegal) begin
                            trap_q <= 1'b1;
                            halted <= 1'b1;
                        end
`endif
                    end
                end else begin
                    state     <= S_IDLE;
                    ack       <= 1'b1;
                    instr_cnt <= instr_cnt + 8'd1;
                    wr_addr   <= f_q;
                    wr_en     <= 1'b1;
                    if (op_q == OP_LDI) begin
                        imm        <= data_bus[3:0];
                        sel_wr_ula <= 1'b1;
                        op_sel     <= 4'h0;
                    end else begin
                        rd_addr1   <= data_bus[6:4];
                        rd_addr2   <= data_bus[2:0];
                        sel_wr_ula <= 1'b0;
                        op_sel     <= op_q;
                    end
                end
            end
        end
    end

`ifndef DECODE_ILLEGAL_TRAP_EN
    logic unused_illegal;
    assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_instr_decode.sv
// tb/tb_instr_decode.sv - randomized and directed self-checking bench for instr_decode
module tb_instr_decode;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] data_bus = 8'h00;
    logic       ack, more, sel_wr_ula, wr_en, halted, trap;
    logic [3:0] op_sel, imm;
    logic [2:0] rd_addr1, rd_addr2, wr_addr;
    logic [7:0] instr_cnt;

    instr_decode dut (
        .clk(clk), .rst(rst), .ena(ena), .data_bus(data_bus),
        .ack(ack), .more(more), .op_sel(op_sel), .rd_addr1(rd_addr1),
        .rd_addr2(rd_addr2), .wr_addr(wr_addr), .imm(imm),
        .sel_wr_ula(sel_wr_ula), .wr_en(wr_en), .halted(halted),
        .trap(trap), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ack_seen = 0;

    // Reference state: bytes of the instruction being assembled plus expected outputs.
    logic [7:0] q[$];
    logic       m_ack = 0, m_sel = 0, m_wr_en = 0, m_halted = 0, m_trap = 0;
    logic [3:0] m_op_sel = 0, m_imm = 0;
    logic [2:0] m_rd1 = 0, m_rd2 = 0, m_wr_addr = 0;
    int         m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int instr_len(input logic [7:0] b0);
        int op;
        op = int'(b0[7:4]);
        return (op >= 1 && op <= 8) ? 2 : 1;
    endfunction

    task automatic execute();
        int op;
        op = int'(q[0][7:4]);
        m_ack = 1;
        m_cnt = (m_cnt + 1) % 256;
        if (op >= 1 && op <= 7) begin
            m_wr_addr = q[0][2:0];
            m_rd1     = q[1][6:4];
            m_rd2     = q[1][2:0];
            m_op_sel  = q[0][7:4];
            m_sel     = 0;
            m_wr_en   = 1;
        end else if (op == 8) begin
            m_wr_addr = q[0][2:0];
            m_imm     = q[1][3:0];
            m_sel     = 1;
            m_wr_en   = 1;
            m_op_sel  = 0;
        end else if (op == 15) begin
            m_wr_en  = 0;
            m_halted = 1;
        end else begin
            m_wr_en = 0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (op != 0) begin
                m_trap   = 1;
                m_halted = 1;
            end
`endif
        end
        q.delete();
    endtask

    task automatic model(input logic r, input logic e, input logic [7:0] d);
        m_ack = 0;
        if (r) begin
            q.delete();
            m_sel = 0; m_wr_en = 0; m_halted = 0; m_trap = 0;
            m_op_sel = 0; m_imm = 0; m_rd1 = 0; m_rd2 = 0; m_wr_addr = 0;
            m_cnt = 0;
        end else if (e && !m_halted) begin
            q.push_back(d);
            if (q.size() == instr_len(q[0]))
                execute();
        end
    endtask

    task automatic compare_all();
        check("ack", ack, m_ack);
        check("more", more, q.size() == 1);
        check("op_sel", op_sel, m_op_sel);
        check("rd_addr1", rd_addr1, m_rd1);
        check("rd_addr2", rd_addr2, m_rd2);
        check("wr_addr", wr_addr, m_wr_addr);
        check("imm", imm, m_imm);
        check("sel_wr_ula", sel_wr_ula, m_sel);
        check("wr_en", wr_en, m_wr_en);
        check("halted", halted, m_halted);
        check("trap", trap, m_trap);
        check("instr_cnt", instr_cnt, m_cnt[7:0]);
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] d);
        rst = r; ena = e; data_bus = d;
        @(posedge clk);
        model(r, e, d);
        #1;
        if (ack === 1'b1) ack_seen++;
        compare_all();
    endtask

    initial begin
        logic [7:0] b;
        logic       r, e;

        step(1, 0, 8'h00);

        // ALU with a gap between bytes
        step(0, 1, 8'h13);
        step(0, 0, 8'h00);
        check("more_gap", more, 1);
        step(0, 0, 8'h00);
        step(0, 1, 8'h52);
        check("alu_ack", ack, 1);
        check("alu_op", op_sel, 1);
        check("alu_wr", wr_addr, 3);
        check("alu_rd1", rd_addr1, 5);
        check("alu_rd2", rd_addr2, 2);
        check("alu_cnt", instr_cnt, 1);

        // LDI keeps previous read addresses
        step(0, 1, 8'h86);
        step(0, 1, 8'h0A);
        check("ldi_imm", imm, 4'hA);
        check("ldi_wr", wr_addr, 6);
        check("ldi_rd1_held", rd_addr1, 5);

        // HALT freezes everything
        step(0, 1, 8'hF0);
        check("halt_flag", halted, 1);
        ack_seen = 0;
        step(0, 1, 8'h13);
        step(0, 1, 8'h52);
        check("halt_no_ack", ack_seen, 0);
        check("halt_cnt", instr_cnt, 3);

        // Reset mid-instruction discards the partial byte
        step(1, 0, 8'h00);
        step(0, 1, 8'h13);
        step(1, 1, 8'h86);
        check("rst_more", more, 0);
        ack_seen = 0;
        step(0, 1, 8'h86);
        step(0, 1, 8'h0A);
        step(0, 0, 8'h00);
        check("rst_one_ack", ack_seen, 1);
        check("rst_cnt", instr_cnt, 1);

        // Illegal opcode
        step(0, 1, 8'hA0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("illegal_trap", trap, 1);
        check("illegal_halt", halted, 1);
`else
        check("illegal_trap", trap, 0);
        check("illegal_halt", halted, 0);
`endif
        check("illegal_wr_en", wr_en, 0);

        // 257 back-to-back NOPs: counter wraps
        step(1, 0, 8'h00);
        ack_seen = 0;
        for (int i = 0; i < 257; i++) step(0, 1, 8'h00);
        check("nop_acks", ack_seen, 257);
        check("nop_cnt", instr_cnt, 1);

        // Random traffic, resetting often enough to escape halts
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 63) == 0) || (m_halted && $urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 2) != 0);
            b = 8'($urandom);
            if ($urandom_range(0, 3) != 0 && b[7:4] > 4'h8) b[7] = 1'b0;
            step(r, e, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
